// File: rtl/pix_reduce_par_pkg.sv
// pix_reduce_par_pkg
//   Shared definitions for the pixel colour-reduction pipeline:
//   mode encodings, statistics counter width and a saturating adder
//   used by the statistics counter.
package pix_reduce_par_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_TRUNC  = 2'b01;
  localparam logic [1:0] MODE_ROUND  = 2'b10;
  localparam logic [1:0] MODE_THRESH = 2'b11;

  localparam int SAT_W = 16;

  // Adds two counter values and sticks at all-ones instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b);
    logic [SAT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SAT_W] ? {SAT_W{1'b1}} : s[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/pix_reduce_par_chan_quant.sv
// chan_quant
//   Combinational quantiser for a single colour channel.
//   Ports:
//     i_c      - input channel value (CW bits)
//     i_mode   - 00 bypass, 01 truncate, 10 round, 11 threshold
//     i_thresh - threshold used in mode 11
//     o_q      - quantised channel value
//     o_sat    - high when rounding overflowed and the result was clamped
module chan_quant
  import pix_reduce_par_pkg::*;
#(
  parameter int CW    = 6,
  parameter int QBITS = 3
) (
  input  logic [CW-1:0] i_c,
  input  logic [1:0]    i_mode,
  input  logic [CW-1:0] i_thresh,
  output logic [CW-1:0] o_q,
  output logic          o_sat
);

  localparam int            LB        = CW - QBITS;
  // Keeps the QBITS most significant bits, zeroes the rest.
  localparam logic [CW-1:0] KEEP_MASK = {{QBITS{1'b1}}, {LB{1'b0}}};
  // Half of one retained LSB; added before masking to round to nearest.
  localparam logic [CW:0]   HALF      = (CW+1)'(1) << (LB - 1);

  logic [CW:0] w_sum;

  // One spare bit so the rounding carry-out is visible.
  assign w_sum = {1'b0, i_c} + HALF;

  always_comb begin
    o_q   = i_c;
    o_sat = 1'b0;
    case (i_mode)
      MODE_BYPASS: o_q = i_c;
      MODE_TRUNC:  o_q = i_c & KEEP_MASK;
      MODE_ROUND: begin
        if (w_sum[CW]) begin
          // Rounding would overflow the channel: clamp to the largest
          // representable quantised level.
          o_q   = KEEP_MASK;
          o_sat = 1'b1;
        end else begin
          o_q = w_sum[CW-1:0] & KEEP_MASK;
        end
      end
      default:     o_q = (i_c >= i_thresh) ? {CW{1'b1}} : {CW{1'b0}};
    endcase
  end

endmodule

// File: rtl/pix_reduce_par.sv
// pix_reduce_par
//   Two-stage pipelined colour reducer. NPIX pixels of three CW-bit
//   channels are quantised in parallel per beat.
//   Ports:
//     clk, reset           - rising-edge clock, synchronous active-low reset
//     in_data/valid/ready  - input beat stream (pixel k at [k*3*CW +: 3*CW],
//                            R high, G middle, B low)
//     mode, thresh         - processing controls, captured with each beat
//     out_data/valid/ready - output beat stream, same packing as input
//     clear_stats          - single-cycle clear of sat_count
//     sat_count            - saturating count of clamped rounding results
//
//   Handshake: a beat moves across an interface on a rising edge where
//   valid and ready are both high. A producer holds valid and data stable
//   until that happens; ready may depend combinationally on out_ready.
module pix_reduce_par
  import pix_reduce_par_pkg::*;
#(
  parameter int NPIX  = 2,
  parameter int CW    = 6,
  parameter int QBITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPIX*3*CW-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           mode,
  input  logic [CW-1:0]        thresh,
  output logic [NPIX*3*CW-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 clear_stats,
  output logic [SAT_W-1:0]     sat_count
);

  localparam int NCH = NPIX * 3;
  localparam int DW  = NCH * CW;

  // Stage 1: raw beat plus the controls it was accepted with.
  logic          r_s1_valid;
  logic [DW-1:0] r_s1_data;
  logic [1:0]    r_s1_mode;
  logic [CW-1:0] r_s1_thresh;
  // Stage 2: processed beat.
  logic          r_s2_valid;
  logic [DW-1:0] r_s2_data;
  logic [SAT_W-1:0] r_sat_count;

  logic [DW-1:0]    w_q;
  logic [NCH-1:0]   w_sat;
  logic [SAT_W-1:0] w_sat_cnt;
  logic             w_s2_load;
  logic             w_s1_adv;

  // S2 can take a new beat when empty or when its beat leaves this cycle.
  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_load;
  // Held high while in reset; anything offered then is discarded anyway.
  assign in_ready  = !reset || !r_s1_valid || w_s1_adv;

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign sat_count = r_sat_count;

  // Channel k occupies [k*CW +: CW] across the whole beat.
  for (genvar k = 0; k < NCH; k++) begin : g_chan
    chan_quant #(
      .CW    (CW),
      .QBITS (QBITS)
    ) u_chan_quant (
      .i_c      (r_s1_data[k*CW +: CW]),
      .i_mode   (r_s1_mode),
      .i_thresh (r_s1_thresh),
      .o_q      (w_q[k*CW +: CW]),
      .o_sat    (w_sat[k])
    );
  end

  always_comb begin
    w_sat_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      w_sat_cnt = w_sat_cnt + SAT_W'(w_sat[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_mode   <= MODE_BYPASS;
      r_s1_thresh <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_data   <= '0;
      r_sat_count <= '0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_data   <= in_data;
          r_s1_mode   <= mode;
          r_s1_thresh <= thresh;
        end
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= w_q;
        end
      end
      // A clear in the same cycle as a transfer drops that beat's events.
      if (clear_stats) begin
        r_sat_count <= '0;
      end else if (w_s1_adv) begin
        r_sat_count <= sat_add(r_sat_count, w_sat_cnt);
      end
    end
  end

endmodule

// File: tb/tb_pix_reduce_par.sv
module tb_pix_reduce_par;
  localparam int NPIX  = 2;
  localparam int CW    = 6;
  localparam int QBITS = 3;
  localparam int DW    = NPIX * 3 * CW;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    mode;
  logic [CW-1:0] thresh;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          clear_stats;
  logic [15:0]   sat_count;

  always #5 clk = ~clk;

  pix_reduce_par #(.NPIX(NPIX), .CW(CW), .QBITS(QBITS)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mode        (mode),
    .thresh      (thresh),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .clear_stats (clear_stats),
    .sat_count   (sat_count)
  );

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  bit            mon_en   = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {p1.R, p1.G, p1.B, p0.R, p0.G, p0.B}
  function automatic logic [DW-1:0] pk(input logic [5:0] p1r, input logic [5:0] p1g,
                                       input logic [5:0] p1b, input logic [5:0] p0r,
                                       input logic [5:0] p0g, input logic [5:0] p0b);
    return {p1r, p1g, p1b, p0r, p0g, p0b};
  endfunction

  function automatic logic [DW-1:0] all6(input logic [5:0] v);
    return {6{v}};
  endfunction

  // Inputs only change 1 time unit after a rising edge; outputs are
  // observed on the falling edge.
  always @(negedge clk) begin
    if (mon_en && reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_beat", 64'(exp_q.size()), 64'd1);
      else                   check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic put(input logic [DW-1:0] d, input logic [1:0] m,
                     input logic [CW-1:0] t, input logic [DW-1:0] e);
    int n;
    in_data  = d;
    mode     = m;
    thresh   = t;
    in_valid = 1'b1;
    exp_q.push_back(e);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("put_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    mode        = 2'b00;
    thresh      = '0;
    out_ready   = 1'b1;
    clear_stats = 1'b0;

    @(negedge clk);
    check("rst_in_ready_during", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_sat_count", 64'(sat_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 reset = 1'b1;

    // truncate, latency
    put(all6(6'h2D), 2'b01, 6'h00, all6(6'h28));
    idle();
    @(negedge clk);
    check("lat_cycle1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    drain();
    check("sat_after_trunc", 64'(sat_count), 64'd0);

    // round: mixed, all saturating, boundaries 3B (no sat) / 3C (sat)
    put(pk(6'h3E, 6'h3E, 6'h3E, 6'h2D, 6'h2D, 6'h2D), 2'b10, 6'h00,
        pk(6'h38, 6'h38, 6'h38, 6'h30, 6'h30, 6'h30));
    put(all6(6'h3E), 2'b10, 6'h00, all6(6'h38));
    put(pk(6'h3C, 6'h00, 6'h1F, 6'h03, 6'h04, 6'h3B), 2'b10, 6'h00,
        pk(6'h38, 6'h00, 6'h20, 6'h00, 6'h08, 6'h38));
    idle();
    drain();
    check("sat_after_round", 64'(sat_count), 64'd10);

    // threshold, bypass, per-beat thresh
    put(pk(6'h00, 6'h21, 6'h1F, 6'h1F, 6'h20, 6'h3F), 2'b11, 6'h20,
        pk(6'h00, 6'h3F, 6'h00, 6'h00, 6'h3F, 6'h3F));
    put(pk(6'h3E, 6'h00, 6'h10, 6'h3F, 6'h01, 6'h2D), 2'b00, 6'h3F,
        pk(6'h3E, 6'h00, 6'h10, 6'h3F, 6'h01, 6'h2D));
    put(all6(6'h20), 2'b11, 6'h21, all6(6'h00));
    put(all6(6'h20), 2'b11, 6'h20, all6(6'h3F));
    idle();
    drain();

    // mode toggle on consecutive beats
    put(all6(6'h2D), 2'b01, 6'h00, all6(6'h28));
    put(all6(6'h2D), 2'b10, 6'h00, all6(6'h30));
    put(all6(6'h3E), 2'b01, 6'h00, all6(6'h38));
    idle();
    drain();
    check("sat_after_toggle", 64'(sat_count), 64'd10);

    // 10-beat stream with a 3-cycle output stall
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [5:0] v;
          v = 6'(i * 5 + 3);
          put(pk(v, ~v, v, 6'(i), v, ~v), 2'b00, 6'h00, pk(v, ~v, v, 6'(i), v, ~v));
        end
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_in_ready_low", 64'(in_ready), 64'd0);
        check("stall_out_valid_held", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // clear coincident with a saturating beat leaving S1
    put(all6(6'h3E), 2'b10, 6'h00, all6(6'h38));
    idle();
    clear_stats = 1'b1;
    @(posedge clk);
    #1 clear_stats = 1'b0;
    check("sat_clear_wins", 64'(sat_count), 64'd0);
    drain();
    check("sat_after_clear", 64'(sat_count), 64'd0);
    put(all6(6'h3E), 2'b10, 6'h00, all6(6'h38));
    idle();
    drain();
    check("sat_count_six", 64'(sat_count), 64'd6);

    // reset mid-stream
    put(all6(6'h11), 2'b00, 6'h00, all6(6'h11));
    put(all6(6'h22), 2'b00, 6'h00, all6(6'h22));
    idle();
    mon_en = 1'b0;
    reset  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_sat", 64'(sat_count), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    mon_en = 1'b1;

    // first beat after reset
    put(all6(6'h2D), 2'b01, 6'h00, all6(6'h28));
    idle();
    @(negedge clk);
    check("post_rst_lat1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("post_rst_lat2", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    drain();
    repeat (3) @(negedge clk);
    check("no_extra_beats", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pix_reduce_par.md
PIX_REDUCE_PAR -- requirements
Module: pix_reduce_par

Interface
REQ-001 Parameter NPIX, default 2, meaning pixels per beat (1..8).
REQ-002 Parameter CW, default 6, meaning bits per colour channel.
REQ-003 Parameter QBITS, default 3, meaning retained bits per channel, with 1 <= QBITS < CW.
REQ-004 Port clk  input  1  is the single clock; all logic is rising-edge.
REQ-005 Port reset  input  1  is a synchronous, active-low reset.
REQ-006 Port in_data  input  NPIX*3*CW  carries pixels: pixel k at [k*3*CW +: 3*CW], and within a pixel R is the high, G the middle and B the low CW bits.
REQ-007 Port in_valid  input  1  indicates in_data is valid.
REQ-008 Port in_ready  output  1  indicates the block accepts a beat this cycle.
REQ-009 Port mode  input  2  selects 00 bypass, 01 truncate, 10 round, 11 threshold; it is sampled with each accepted beat.
REQ-010 Port thresh  input  CW  is the threshold for mode 11, sampled with each accepted beat.
REQ-011 Port out_data  output  NPIX*3*CW  uses the same packing as in_data.
REQ-012 Port out_valid  output  1  indicates out_data is valid.
REQ-013 Port out_ready  input  1  indicates the downstream accepts the beat.
REQ-014 Port clear_stats  input  1  is a single-cycle clear of sat_count.
REQ-015 Port sat_count  output  16  counts saturated channels.

Function
REQ-016 A beat transfers on input when in_valid & in_ready, and on output when out_valid & out_ready.
REQ-017 The datapath is two register stages: S1 holds the input beat with its mode and thresh; S2 holds the processed result.
REQ-018 Latency with no stall is 2 cycles from input acceptance to out_valid.
REQ-019 With no stall, throughput is one beat per cycle.
REQ-020 Each stage loads when it is empty or its contents advance in the same cycle.
REQ-021 in_ready is !S1_valid | (S1 advancing into S2), and is combinational from out_ready.
REQ-022 A stalled stage holds its data, mode and thresh unchanged; no beat is dropped or duplicated.
REQ-023 Bypass: each output channel equals the input channel.
REQ-024 Truncate: each output channel equals the input channel with its low CW-QBITS bits forced to 0.
REQ-025 Round, step 1: compute c + 2^(CW-QBITS-1) in CW+1 bits.
REQ-026 Round, step 2: if the carry-out is set, the output is the top QBITS bits all ones with the low bits 0; this is a saturation event.
REQ-027 Round, step 3: otherwise, the low CW-QBITS bits of the sum are masked to 0.
REQ-028 Threshold: each output channel is all ones if c >= thresh, otherwise 0.
REQ-029 All NPIX*3 channels are processed in parallel with identical logic.
REQ-030 sat_count adds the number of saturation events in a beat as that beat moves S1->S2.
REQ-031 sat_count saturates at 16'hFFFF and does not wrap.
REQ-032 clear_stats sets sat_count to 0 on the next edge; if a beat moves S1->S2 in the same cycle, clear wins and that beat's events are discarded.
REQ-033 Changing mode or thresh affects only beats accepted after the change.

Reset
REQ-034 While reset = 0 at a clock edge, S1_valid, out_valid, out_data and sat_count are set to 0.
REQ-035 in_ready is 1 during and after reset.
REQ-036 A beat in flight when reset asserts is discarded.
REQ-037 The first beat accepted after reset behaves identically to the first beat after power-up.

Structure
REQ-038 A shared package holds the mode encodings (MODE_BYPASS, MODE_TRUNC, MODE_ROUND, MODE_THRESH) and the sat_count width constant.
REQ-039 One sub-module, chan_quant, is combinational: it takes one CW-bit channel plus mode and thresh, and returns the quantised channel and a saturation flag.
REQ-040 pix_reduce_par instantiates chan_quant NPIX*3 times via generate.

Verification
REQ-041 Defaults, truncate, R=G=B=6'h2D on both pixels -> out 6'h28 per channel, 2 cycles after acceptance.
REQ-042 Round, channel 6'h2D -> 6'h30; channel 6'h3E -> 6'h38 with sat_count incrementing by 1 per saturated channel (6 for all channels).
REQ-043 Threshold with thresh=6'h20: channel 6'h1F -> 6'h00, channel 6'h20 -> 6'h3F.
REQ-044 Stream 10 beats with out_ready low for 3 cycles mid-stream -> all 10 beats emerge in order, unmodified by the stall, and in_ready drops once both stages are full.
REQ-045 Mode toggles 01 -> 10 on consecutive beats -> each output is processed with its own beat's mode.
REQ-046 clear_stats coincident with a saturating beat -> sat_count reads 0; reset asserted mid-stream -> out_valid=0 on the next cycle.
